// File: rtl/if_stage.sv
// Instruction fetch stage: PC, credit-limited imem requests, fetch buffer to decode.
// Optional perf counters enabled by defining IF_PERF_CNT_EN.
module if_stage #(
    parameter int                    DATA_WIDTH = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_PC   = '0,
    parameter int                    FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  imem_req_o,
    output logic [DATA_WIDTH-1:0] imem_addr_o,
    input  logic                  imem_gnt_i,
    input  logic                  imem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] imem_rdata_i,
    input  logic                  redirect_i,
    input  logic [DATA_WIDTH-1:0] redirect_pc_i,
    input  logic                  stall_i,
    output logic                  instr_valid_o,
    output logic [DATA_WIDTH-1:0] instruction_o,
    output logic [DATA_WIDTH-1:0] pc_o,
    output logic [DATA_WIDTH-1:0] pc_plus4_o,
    output logic [31:0]           fetch_cnt_o,
    output logic [31:0]           drop_cnt_o
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    logic [DATA_WIDTH-1:0] pc_q;
    logic [DATA_WIDTH-1:0] last_pc_q;
    logic                  fetch_en_q;
    logic [DATA_WIDTH-1:0] buf_instr [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] buf_pc    [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] fl_pc     [FIFO_DEPTH];
    logic [AW-1:0]         buf_rd, buf_wr, fl_rd, fl_wr;
    logic [CW-1:0]         buf_cnt, outstanding, drop_q, out_next;
    logic                  credit_ok, accept, resp, discard, push, pop;
    logic                  unused_low_bits;

    assign unused_low_bits = ^redirect_pc_i[1:0];

    assign credit_ok = ({1'b0, outstanding} + {1'b0, buf_cnt})
                       < (CW+1)'(FIFO_DEPTH);
    assign imem_req_o  = fetch_en_q && !redirect_i && credit_ok;
    assign imem_addr_o = pc_q;

    assign accept  = imem_req_o && imem_gnt_i;
    // A response with nothing outstanding is a protocol error and is ignored.
    assign resp    = imem_rvalid_i && (outstanding != '0);
    assign discard = resp && ((drop_q != '0) || redirect_i);
    assign push    = resp && (drop_q == '0) && !redirect_i;
    assign pop     = instr_valid_o && !stall_i;

    assign out_next = outstanding + CW'(accept) - CW'(resp);

    assign instr_valid_o = (buf_cnt != '0);
    assign instruction_o = instr_valid_o ? buf_instr[buf_rd] : NOP;
    assign pc_o          = instr_valid_o ? buf_pc[buf_rd] : last_pc_q;
    assign pc_plus4_o    = pc_o + DATA_WIDTH'(4);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q        <= RESET_PC;
            last_pc_q   <= RESET_PC;
            fetch_en_q  <= 1'b0;
            buf_rd      <= '0;
            buf_wr      <= '0;
            fl_rd       <= '0;
            fl_wr       <= '0;
            buf_cnt     <= '0;
            outstanding <= '0;
            drop_q      <= '0;
        end else begin
            fetch_en_q  <= 1'b1;
            outstanding <= out_next;
            if (accept) begin
                pc_q  <= pc_q + DATA_WIDTH'(4);
                fl_wr <= fl_wr + AW'(1);
            end
            if (resp)
                fl_rd <= fl_rd + AW'(1);
            if (instr_valid_o)
                last_pc_q <= buf_pc[buf_rd];
            if (redirect_i) begin
                pc_q    <= {redirect_pc_i[DATA_WIDTH-1:2], 2'b00};
                buf_rd  <= '0;
                buf_wr  <= '0;
                buf_cnt <= '0;
                drop_q  <= out_next;
            end else begin
                if (push)
                    buf_wr <= buf_wr + AW'(1);
                if (pop)
                    buf_rd <= buf_rd + AW'(1);
                buf_cnt <= buf_cnt + CW'(push) - CW'(pop);
                if (resp && (drop_q != '0))
                    drop_q <= drop_q - CW'(1);
            end
        end
    end

    // Data-only storage; validity is tracked by the counters above.
    always_ff @(posedge clk) begin
        if (push) begin
            buf_instr[buf_wr] <= imem_rdata_i;
            buf_pc[buf_wr]    <= fl_pc[fl_rd];
        end
        if (accept)
            fl_pc[fl_wr] <= pc_q;
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt_q <= '0;
            drop_cnt_q  <= '0;
        end else begin
            if (pop)
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (discard)
                drop_cnt_q <= drop_cnt_q + 32'd1;
        end
    end

    assign fetch_cnt_o = fetch_cnt_q;
    assign drop_cnt_o  = drop_cnt_q;
`else
    logic unused_discard;
    assign unused_discard = discard;
    assign fetch_cnt_o    = '0;
    assign drop_cnt_o     = '0;
`endif

    rvalid_needs_outstanding: assert property (
        @(posedge clk) disable iff (!rst_n)
        imem_rvalid_i |-> (outstanding != '0)
    );

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed table, corner sequences, random traffic vs queue model.
module tb_if_stage;
    localparam int          DW    = 32;
    localparam int          DEPTH = 2;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          imem_req_o;
    logic [DW-1:0] imem_addr_o;
    logic          imem_gnt_i = 1'b0;
    logic          imem_rvalid_i = 1'b0;
    logic [DW-1:0] imem_rdata_i = '0;
    logic          redirect_i = 1'b0;
    logic [DW-1:0] redirect_pc_i = '0;
    logic          stall_i = 1'b0;
    logic          instr_valid_o;
    logic [DW-1:0] instruction_o;
    logic [DW-1:0] pc_o;
    logic [DW-1:0] pc_plus4_o;
    logic [31:0]   fetch_cnt_o;
    logic [31:0]   drop_cnt_o;

    if_stage #(.DATA_WIDTH(DW), .RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o),
        .imem_gnt_i(imem_gnt_i), .imem_rvalid_i(imem_rvalid_i),
        .imem_rdata_i(imem_rdata_i),
        .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
        .stall_i(stall_i),
        .instr_valid_o(instr_valid_o), .instruction_o(instruction_o),
        .pc_o(pc_o), .pc_plus4_o(pc_plus4_o),
        .fetch_cnt_o(fetch_cnt_o), .drop_cnt_o(drop_cnt_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        bit          stall;
        bit          req;
        logic [31:0] addr;
        bit          valid;
        logic [31:0] pc;
    } vec_t;

    int n_vec = 0;
    int n_err = 0;

    // Reference: memory queue plus abstract stage state
    logic [31:0] mem_q[$];
    logic [31:0] m_infl[$];
    ent_t        m_fifo[$];
    logic [31:0] m_pc, m_last_pc, m_fcnt, m_dcnt;
    int          m_drop;

    logic        s_req, s_valid;
    logic [31:0] s_addr, s_pc, s_instr, s_pc4;

    function automatic logic [31:0] instr_of(input logic [31:0] a);
        return {a[15:0] ^ 16'h5A5A, a[31:16] ^ 16'hC3C3};
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mem_q.delete();
        m_infl.delete();
        m_fifo.delete();
        m_pc      = RPC;
        m_last_pc = RPC;
        m_fcnt    = '0;
        m_dcnt    = '0;
        m_drop    = 0;
    endtask

    task automatic step(input bit gnt, input bit rv_en, input bit red,
                        input logic [31:0] rpc, input bit st);
        bit          e_req, e_valid;
        logic [31:0] e_pc, e_instr, p;
        @(posedge clk);
        #1;
        imem_gnt_i    = gnt;
        stall_i       = st;
        redirect_i    = red;
        redirect_pc_i = rpc;
        if (rv_en && mem_q.size() > 0) begin
            imem_rvalid_i = 1'b1;
            imem_rdata_i  = instr_of(mem_q.pop_front());
        end else begin
            imem_rvalid_i = 1'b0;
            imem_rdata_i  = $urandom;
        end
        @(negedge clk);
        e_req   = !red && (m_infl.size() + m_fifo.size() < DEPTH);
        e_valid = m_fifo.size() != 0;
        e_pc    = e_valid ? m_fifo[0].pc : m_last_pc;
        e_instr = e_valid ? m_fifo[0].instr : NOP;
        chk("req", 32'(imem_req_o), 32'(e_req));
        chk("addr", imem_addr_o, m_pc);
        chk("valid", 32'(instr_valid_o), 32'(e_valid));
        chk("instr", instruction_o, e_instr);
        chk("pc", pc_o, e_pc);
        chk("pc4", pc_plus4_o, e_pc + 32'd4);
`ifdef IF_PERF_CNT_EN
        chk("fetch_cnt", fetch_cnt_o, m_fcnt);
        chk("drop_cnt", drop_cnt_o, m_dcnt);
`else
        chk("fetch_cnt", fetch_cnt_o, 32'd0);
        chk("drop_cnt", drop_cnt_o, 32'd0);
`endif
        s_req = imem_req_o; s_valid = instr_valid_o; s_addr = imem_addr_o;
        s_pc = pc_o; s_instr = instruction_o; s_pc4 = pc_plus4_o;
        if (imem_req_o && imem_gnt_i)
            mem_q.push_back(imem_addr_o);
        if (e_valid)
            m_last_pc = m_fifo[0].pc;
        if (e_valid && !st) begin
            void'(m_fifo.pop_front());
            m_fcnt++;
        end
        if (imem_rvalid_i) begin
            p = m_infl.pop_front();
            if (red || m_drop > 0) begin
                m_dcnt++;
                if (m_drop > 0) m_drop--;
            end else begin
                m_fifo.push_back('{instr: imem_rdata_i, pc: p});
            end
        end
        if (e_req && gnt) begin
            m_infl.push_back(m_pc);
            m_pc = m_pc + 32'd4;
        end
        if (red) begin
            m_pc = {rpc[31:2], 2'b00};
            m_fifo.delete();
            m_drop = m_infl.size();
        end
    endtask

    task automatic do_reset();
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0;
        redirect_i = 1'b0; stall_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_valid(input string name, input logic [31:0] exp_pc);
        bit got = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            step(1, 1, 0, 0, 0);
            if (s_valid) got = 1;
        end
        if (!got) begin
            n_vec++; n_err++;
            $display("FAIL %s: no valid within 20 cycles, expected pc %h", name, exp_pc);
        end else begin
            chk(name, s_pc, exp_pc);
            chk({name, "_instr"}, s_instr, instr_of(exp_pc));
        end
    endtask

    vec_t tbl[12];
    logic [31:0] hold_pc, hold_instr;
    bit          have_hold;

    initial begin
        tbl[0]  = '{0, 1, 32'h00, 0, 32'h00};
        tbl[1]  = '{0, 1, 32'h04, 0, 32'h00};
        tbl[2]  = '{0, 0, 32'h08, 1, 32'h00};
        tbl[3]  = '{0, 1, 32'h08, 1, 32'h04};
        tbl[4]  = '{0, 1, 32'h0C, 0, 32'h04};
        tbl[5]  = '{0, 0, 32'h10, 1, 32'h08};
        tbl[6]  = '{0, 1, 32'h10, 1, 32'h0C};
        tbl[7]  = '{1, 1, 32'h14, 0, 32'h0C};
        tbl[8]  = '{1, 0, 32'h18, 1, 32'h10};
        tbl[9]  = '{1, 0, 32'h18, 1, 32'h10};
        tbl[10] = '{0, 0, 32'h18, 1, 32'h10};
        tbl[11] = '{0, 1, 32'h18, 1, 32'h14};

        model_reset();
        #12;
        chk("rst_req", 32'(imem_req_o), 32'd0);
        chk("rst_valid", 32'(instr_valid_o), 32'd0);
        chk("rst_instr", instruction_o, NOP);
        chk("rst_pc", pc_o, RPC);
        chk("rst_pc4", pc_plus4_o, RPC + 32'd4);
        chk("rst_fcnt", fetch_cnt_o, 32'd0);
        chk("rst_dcnt", drop_cnt_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Startup and stall, 1-cycle memory
        for (int i = 0; i < 12; i++) begin
            step(1, 1, 0, 0, tbl[i].stall);
            chk($sformatf("tbl%0d_req", i), 32'(s_req), 32'(tbl[i].req));
            chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
            chk($sformatf("tbl%0d_valid", i), 32'(s_valid), 32'(tbl[i].valid));
            chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].pc);
            if (tbl[i].valid)
                chk($sformatf("tbl%0d_instr", i), s_instr, instr_of(tbl[i].pc));
        end

        // Five stall cycles in steady state hold the head instruction
        have_hold = 0;
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 0, 0, 1);
            if (s_valid && !have_hold) begin
                have_hold = 1; hold_pc = s_pc; hold_instr = s_instr;
            end else if (have_hold) begin
                chk("stall_pc", s_pc, hold_pc);
                chk("stall_instr", s_instr, hold_instr);
            end
        end
        repeat (6) step(1, 1, 0, 0, 0);

        // Redirect with two responses in flight
        do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 1, 32'h0000_0103, 0);
        wait_valid("redir_pc", 32'h0000_0100);
`ifdef IF_PERF_CNT_EN
        chk("redir_drop_cnt", drop_cnt_o, 32'd2);
`endif

        // Redirect coinciding with grant and response
        do_reset();
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 1, 1, 32'h0000_0200, 0);
        wait_valid("redir_same_pc", 32'h0000_0200);

        // PC wrap
        do_reset();
        step(1, 1, 1, 32'hFFFF_FFFE, 0);
        step(1, 1, 0, 0, 0);
        chk("wrap_addr0", s_addr, 32'hFFFF_FFFC);
        step(1, 1, 0, 0, 0);
        chk("wrap_addr1", s_addr, 32'h0000_0000);
        wait_valid("wrap_pc", 32'hFFFF_FFFC);
        chk("wrap_pc4", s_pc4, 32'h0000_0000);

        // Reset mid-burst with a full buffer
        do_reset();
        repeat (6) step(1, 1, 0, 0, 1);
        chk("full_valid", 32'(s_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_req", 32'(imem_req_o), 32'd0);
        chk("midrst_valid", 32'(instr_valid_o), 32'd0);
        chk("midrst_pc", pc_o, RPC);
        model_reset();
        imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; stall_i = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 1, 0, 0, 0);
        chk("restart_req", 32'(s_req), 32'd1);
        chk("restart_addr", s_addr, RPC);

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) do_reset();
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 19) == 0, $urandom,
                 $urandom_range(0, 3) == 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage directly upstream of the decode stage.
- Owns the PC register and issues word fetches to instruction memory over a request/grant + in-order response interface.
- Buffers returned instructions with their PCs in a small FIFO and presents one instruction per cycle to decode.
- Honours decode stalls and branch/jump redirects from execute.

Parameters:
- DATA_WIDTH, 32, width of PC, address and instruction words.
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- FIFO_DEPTH, 2, fetch buffer entries; also the maximum number of in-flight requests plus buffered entries (power of two, >=2).

Ports:
- clk  input  1  stage clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- imem_req_o  output  1  fetch request valid.
- imem_addr_o  output  DATA_WIDTH  fetch address; always equals current PC.
- imem_gnt_i  input  1  request accepted this cycle (qualified by imem_req_o).
- imem_rvalid_i  input  1  response data valid; responses return in order, at least 1 cycle after grant.
- imem_rdata_i  input  DATA_WIDTH  instruction word.
- redirect_i  input  1  taken branch/jump; load new PC.
- redirect_pc_i  input  DATA_WIDTH  redirect target.
- stall_i  input  1  decode cannot accept; hold the output instruction.
- instr_valid_o  output  1  instruction_o/pc_o are valid.
- instruction_o  output  DATA_WIDTH  instruction to decode.
- pc_o  output  DATA_WIDTH  PC of instruction_o.
- pc_plus4_o  output  DATA_WIDTH  pc_o + 4, used for link writeback.
- fetch_cnt_o  output  32  instructions delivered to decode (see Optional Feature).
- drop_cnt_o  output  32  responses discarded after redirect (see Optional Feature).

Behaviour:
- Reset (async assert, sync-deasserted use): PC=RESET_PC, imem_req_o=0, FIFO empty, outstanding=0, drop=0, instr_valid_o=0, instruction_o=32'h0000_0013 (NOP), pc_o=RESET_PC, pc_plus4_o=RESET_PC+4, counters=0.
- Credit rule: imem_req_o=1 iff !redirect_i && (outstanding + fifo_count) < FIFO_DEPTH. First request occurs the cycle after reset release.
- Accept: on imem_req_o && imem_gnt_i, PC <= PC+4 (modulo 2^DATA_WIDTH wrap) and outstanding++.
- Response: on imem_rvalid_i, outstanding--.
  - If drop>0: discard the data, drop--.
  - Otherwise push {imem_rdata_i, pc_of_request} into the FIFO. PCs of in-flight requests are tracked internally.
- Output: FIFO head drives instruction_o/pc_o combinationally from registered storage.
  - instr_valid_o = !empty.
  - Pop when instr_valid_o && !stall_i.
  - When empty, instruction_o=NOP and pc_o holds its last value.
  - Same-cycle push and pop on a full FIFO is legal: count unchanged.
- Redirect (highest priority):
  - PC <= {redirect_pc_i[DW-1:2], 2'b00}.
  - FIFO flushed; instr_valid_o=0 next cycle.
  - drop <= outstanding after this cycle's updates, so a grant in the same cycle is counted and a same-cycle rvalid is discarded.
  - No request is issued in the redirect cycle.
- Stall: FIFO holds its contents; fetching continues until credit is exhausted. A redirect overrides stall.
- Overflow is impossible by the credit rule. An rvalid with outstanding==0 is a protocol error: ignored, with an assertion.
- Reset mid-operation: all state cleared immediately. In-flight memory responses after reset are the memory's responsibility; the memory is reset by the same rst_n.

Optional Feature:
- IF_PERF_CNT_EN defined:
  - fetch_cnt_o increments on each pop.
  - drop_cnt_o increments on each discarded response.
  - Both wrap at 2^32 and reset to 0.
- Undefined: both ports tied to 0 and no counter flops are inferred.

Test Plan:
- Reset release, memory with gnt=1 and 1-cycle rvalid, stall=0 -> addresses 0x0,0x4,0x8… issued; decode sees instr_valid_o=1 from cycle 3 with pc_o=0x0, then one instruction per cycle; pc_plus4_o=pc_o+4.
- stall_i=1 held 5 cycles in steady state -> at most FIFO_DEPTH requests outstanding-or-buffered; instruction_o/pc_o unchanged for the whole stall; on release, resumes in-order with no loss or duplication.
- redirect_i with redirect_pc_i=0x0000_0103 while 2 responses are in flight -> both responses discarded (drop_cnt_o=2 with IF_PERF_CNT_EN); next delivered pc_o=0x0000_0100.
- redirect_i in the same cycle as imem_gnt_i and imem_rvalid_i -> granted old-PC request and same-cycle response are never delivered; first delivered PC is the target.
- PC=0xFFFF_FFFC fetched -> next fetch address 0x0000_0000 (wrap).
- rst_n asserted mid-burst with FIFO full -> instr_valid_o=0 and imem_req_o=0 immediately; after release, fetch restarts at RESET_PC.
